// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage
// and the data memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-memory handshake, upstream stall,
// registered write-back and branch-resolve outputs.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic        ex_branch,
    input  logic [31:0] ex_aluR,
    input  logic [31:0] ex_inB,
    input  logic [4:0]  ex_destR,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  EXE_ins_type,
    input  logic [3:0]  EXE_ins_number,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        mem_wreg,
    output logic        mem_m2reg,
    output logic [31:0] mem_aluR,
    output logic [31:0] mem_mdata,
    output logic [4:0]  mem_destR,
    output logic        mem_branch,
    output logic [31:0] mem_pc,
    output logic        mem_err,
    output logic [3:0]  MEM_ins_type,
    output logic [3:0]  MEM_ins_number
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        h_wreg;
    logic        h_m2reg;
    logic [4:0]  h_destR;
    logic [31:0] h_aluR;
    logic [3:0]  h_type;
    logic [3:0]  h_num;

    logic memop;
    logic misaligned;
    logic last;

    assign memop      = ex_m2reg | ex_wmem;
    assign misaligned = ex_aluR[1:0] != 2'b00;
    assign last       = cnt == LAST;

    // Reset forces the stall low even while EX presents a memop.
    assign mem_stall = rst & (
        (state == IDLE & memop & ~misaligned) |
        (state == ACCESS & ~dmem.dmem_ack & ~last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            h_wreg          <= 1'b0;
            h_m2reg         <= 1'b0;
            h_destR         <= '0;
            h_aluR          <= '0;
            h_type          <= '0;
            h_num           <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            mem_wreg        <= 1'b0;
            mem_m2reg       <= 1'b0;
            mem_aluR        <= '0;
            mem_mdata       <= '0;
            mem_destR       <= '0;
            mem_branch      <= 1'b0;
            mem_pc          <= '0;
            mem_err         <= 1'b0;
            MEM_ins_type    <= '0;
            MEM_ins_number  <= '0;
        end else begin
            // Bubble by default; each path overrides what it delivers.
            mem_wreg       <= 1'b0;
            mem_m2reg      <= 1'b0;
            mem_aluR       <= '0;
            mem_mdata      <= '0;
            mem_destR      <= '0;
            mem_branch     <= 1'b0;
            mem_pc         <= '0;
            mem_err        <= 1'b0;
            MEM_ins_type   <= '0;
            MEM_ins_number <= '0;
            case (state)
                IDLE: begin
                    if (memop && misaligned) begin
                        mem_err <= 1'b1;
                    end else if (memop) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= ex_wmem;
                        dmem.dmem_addr  <= ex_aluR;
                        dmem.dmem_wdata <= ex_inB;
                        h_wreg          <= ex_wreg;
                        h_m2reg         <= ex_m2reg;
                        h_destR         <= ex_destR;
                        h_aluR          <= ex_aluR;
                        h_type          <= EXE_ins_type;
                        h_num           <= EXE_ins_number;
                        cnt             <= '0;
                        state           <= ACCESS;
                    end else begin
                        mem_wreg       <= ex_wreg;
                        mem_m2reg      <= ex_m2reg;
                        mem_aluR       <= ex_aluR;
                        mem_destR      <= ex_destR;
                        mem_branch     <= ex_branch;
                        mem_pc         <= ex_pc;
                        MEM_ins_type   <= EXE_ins_type;
                        MEM_ins_number <= EXE_ins_number;
                    end
                end
                ACCESS: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req  <= 1'b0;
                        mem_wreg       <= h_wreg;
                        mem_m2reg      <= h_m2reg;
                        mem_aluR       <= h_aluR;
                        mem_destR      <= h_destR;
                        mem_mdata      <= h_m2reg ? dmem.dmem_rdata : '0;
                        MEM_ins_type   <= h_type;
                        MEM_ins_number <= h_num;
                        state          <= IDLE;
                    end else if (last) begin
                        dmem.dmem_req <= 1'b0;
                        mem_err       <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage; sits between the execute-stage output registers and write-back.
- Consumes the registered EX results (ALU result, store data, destination register, control bits, branch target).
- Runs a req/ack handshake to the data memory for loads and stores and stalls the upstream pipeline while an access is outstanding.
- Presents registered results to write-back and the branch-resolve signals to fetch.

Parameters:
- TIMEOUT, 16, maximum ACCESS cycles without dmem_ack before the access is abandoned.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous, active-low (asserted at 0).
- ex_wreg, ex_m2reg, ex_wmem, ex_branch  in  1 each  control bits from EX.
- ex_aluR  in  32  ALU result; used as memory byte address for loads and stores.
- ex_inB  in  32  store data.
- ex_destR  in  5  write-back register number.
- ex_pc  in  32  branch target.
- EXE_ins_type, EXE_ins_number  in  4 each  debug tags.
- dmem_req  out  1  memory request, level, held until ack or timeout.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word-aligned byte address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  load data.
- mem_stall  out  1  combinational; holds EX/ID/IF registers when 1.
- mem_wreg, mem_m2reg  out  1 each  to write-back.
- mem_aluR, mem_mdata  out  32 each  ALU result and load data.
- mem_destR  out  5  destination register.
- mem_branch  out  1  taken-branch pulse to fetch.
- mem_pc  out  32  branch target.
- mem_err  out  1  one-cycle pulse on a misaligned access or timeout.
- MEM_ins_type, MEM_ins_number  out  4 each  debug tags.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - Every output register goes to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, all mem_* outputs, MEM_ins_*.
  - mem_stall evaluates to 0 while reset is asserted.
- Definitions:
  - memop = ex_m2reg | ex_wmem.
  - misaligned = ex_aluR[1:0] != 0.
- States: IDLE, ACCESS.
- IDLE, non-memop:
  - At the next edge the outputs register the EX values (mem_mdata <= 0, mem_branch <= ex_branch, mem_err <= 0).
  - Latency is 1 cycle; mem_stall = 0.
- IDLE, memop and misaligned:
  - No request is issued.
  - At the next edge: mem_err <= 1, bubble outputs (mem_wreg = mem_m2reg = mem_branch = 0, MEM_ins_* = 0).
  - mem_stall = 0; the instruction is dropped.
- IDLE, memop and aligned:
  - mem_stall = 1 combinationally.
  - At the next edge: dmem_req <= 1, dmem_we <= ex_wmem, dmem_addr <= ex_aluR, dmem_wdata <= ex_inB.
  - Capture ex_wreg, ex_m2reg, ex_destR, ex_aluR and the tags into holding registers; counter <= 0; go to ACCESS.
  - Outputs become a bubble.
- ACCESS:
  - dmem_req/we/addr/wdata are held constant.
  - Outputs remain a bubble until completion.
  - mem_stall = ~dmem_ack & ~(counter == TIMEOUT-1).
- ACCESS, dmem_ack = 1:
  - mem_stall = 0 in that same cycle, so upstream advances at this edge.
  - At the edge: drop dmem_req; register the held values to the outputs, with mem_mdata <= dmem_rdata for loads and 0 for stores; go to IDLE.
  - Minimum memop latency is 2 cycles from EX presentation to the write-back outputs.
- ACCESS, no ack:
  - counter increments.
  - At counter == TIMEOUT-1 without ack: mem_err <= 1, bubble outputs, drop dmem_req, go to IDLE; mem_stall = 0 in that cycle.
  - Write-back is suppressed.
- dmem_ack while in IDLE is ignored.
- An ack arriving in the same cycle as the timeout has priority: the access completes normally.
- mem_err and mem_branch are single-cycle pulses.
- Reset during ACCESS aborts the request immediately (dmem_req goes to 0 asynchronously); no write-back occurs.
- Upstream contract: while mem_stall = 1, the ex_* inputs hold stable.

Test Plan:
1. Back-to-back ALU ops: ex_wreg=1, ex_aluR=0x10 then 0x20, ex_destR=3 then 4 -> mem_aluR 0x10/0x20 with mem_destR 3/4 on consecutive cycles; mem_stall stays 0.
2. Load at 0x40, ack on the 3rd ACCESS cycle with rdata=0xDEADBEEF -> dmem_req high for 3 cycles, we=0, addr=0x40; mem_stall high for 3 cycles; then mem_m2reg=1, mem_mdata=0xDEADBEEF, mem_wreg=1.
3. Store ex_wmem=1, addr=0x8, inB=0x1234, ack on the 1st ACCESS cycle -> dmem_we=1, wdata=0x1234; stall high for exactly 1 cycle; write-back outputs show mem_wreg=0.
4. Misaligned load at 0x42 -> dmem_req never rises, mem_err pulses 1 cycle, bubble outputs, mem_stall=0.
5. Load with no ack, TIMEOUT=16 -> dmem_req high for 16 cycles, then mem_err pulse, mem_wreg=0, stall released; a following ALU op completes normally.
6. Drive rst=0 mid-ACCESS -> dmem_req, mem_stall and all outputs go to 0 without waiting for a clock edge; after release, a load completes normally.
